tx_os_scheduler: RTL and testbench
==================================

# tx_os_scheduler

Transmit-side symbol scheduler that sits directly in front of `encoder_8b10` on each lane. It sequences TS1/TS2 training ordered sets on LTSSM request and inserts SKP ordered sets at a fixed interval. It fills every remaining symbol slot with logical idle (D0.0). It drives the encoder's `en`/`kin`/`din` inputs and monitors its `kin_err` output.

## Interface
- `SKP_INTERVAL`, default 1180: enabled symbol slots between SKP ordered-set starts.
- `SKP_LEN`, default 3: SKP symbols following COM in a SKP ordered set (1..4).
- `clk` in 1: symbol clock.
- `rst` in 1: asynchronous, active-high reset.
- `sym_en` in 1: symbol-slot enable. When low, the block holds all state.
- `ts_req` in 1: level; LTSSM requests training sets.
- `ts_type` in 1: 0 = TS1, 1 = TS2.
- `link_pad`, `lane_pad` in 1 each: send PAD (K23.7) instead of the number.
- `link_num`, `lane_num`, `n_fts`, `rate_id`, `train_ctl` in 8 each: TS symbols 1..5.
- `kerr_clr` in 1: clears `kerr_sticky`.
- `enc_kin_err` in 1: from encoder `kin_err`.
- `enc_en` out 1, `enc_kin` out 1, `enc_din` out 8: to encoder.
- `ts_done` out 1: one-cycle pulse on the last TS symbol.
- `skp_sent` out 1: one-cycle pulse on the COM symbol of a SKP ordered set.
- `os_active` out 1: high while a TS or SKP symbol is being output.
- `kerr_sticky` out 1: latched encoder K-code error.

## Operation
- **States:** IDLE, TS, SKP. A 4-bit symbol index `sidx` runs within TS and SKP.
- **Boundary:** a slot where the state is IDLE, or where the last symbol of the current ordered set is being issued (TS `sidx`=15, SKP `sidx`=SKP_LEN).
- **Decision at a boundary, in priority order:**
  - `skp_pending` -> SKP.
  - `ts_req` -> TS.
  - Otherwise -> IDLE.
- **Back-to-back sets:** consecutive ordered sets are issued with no gap slot.
- **TS contents (`sidx` 0..15):**
  - 0: COM, K28.5 = 0xBC, k=1.
  - 1: link_num, or PAD 0xF7 k=1 if `link_pad`.
  - 2: lane_num, or PAD 0xF7 k=1 if `lane_pad`.
  - 3: n_fts.
  - 4: rate_id.
  - 5: train_ctl.
  - 6..15: ID, D10.2 = 0x4A for TS1 or D5.2 = 0x45 for TS2.
- **TS field capture:** `ts_type`, pads and fields are captured when COM is issued and held for the whole set.
- **TS completion:** a started TS always runs all 16 symbols, even if `ts_req` deasserts.
- **SKP contents:** COM (0xBC, k=1), then SKP_LEN × K28.0 = 0x1C, k=1.
- **IDLE contents:** 0x00, k=0.
- **SKP timer:**
  - Counts enabled slots.
  - At SKP_INTERVAL-1 it sets `skp_pending` and saturates.
  - Reloads to 0 and clears `skp_pending` in the slot where the SKP COM is issued.
  - A SKP never preempts a TS; it waits for the TS boundary.
- **Stall:** `sym_en`=0 freezes state, `sidx`, timer and captured fields. `enc_en`=0; `enc_din`/`enc_kin` hold their values; no pulses.
- **K-code error:** `enc_kin_err`=1 sets `kerr_sticky`. `kerr_clr` clears it. If set and clear occur in the same cycle, set wins.

## Timing
- All outputs are registered. A slot decided in cycle N (with `sym_en`=1) appears on `enc_*` in N+1.
- The encoder adds one more cycle, so a symbol appears on the 10-bit output at N+2.
- `enc_en` equals `sym_en` delayed by one cycle.
- `ts_done` and `skp_sent` are aligned with the `enc_*` symbol they flag.
- **Reset values:** state IDLE, `sidx`=0, timer 0, `skp_pending`=0; every output 0, including `enc_din`=0x00 and `kerr_sticky`=0.
- **Reset mid-set:** the ordered set is abandoned immediately. The first slot after reset release is IDLE unless `ts_req` is high, in which case TS starts with COM.
- **Simultaneous events:** `ts_req` rising in the same slot as `skp_pending` setting produces the SKP first, then TS at the next boundary.

## Structure
- **`pcie_sym_pkg`:**
  - Symbol constants: COM 0xBC, SKP 0x1C, PAD 0xF7, TS1_ID 0x4A, TS2_ID 0x45, IDL 0x00.
  - TS_LEN=16.
  - State enum {IDLE, TS, SKP}.
- **Sub-module `skp_timer`:** the interval counter plus `skp_pending`. Inputs: `clk`, `rst`, `sym_en`, `reload`. Output: `pending`.
- **Top level:** FSM, field capture registers, output mux registers and sticky error.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately. Release with `sym_en`=1 and `ts_req`=0 -> `enc_en`=1, `enc_din`=0x00, `enc_kin`=0 from the next cycle.
- **Single TS1:** `ts_req` for 1 slot, link 0x01, lane 0x00, n_fts 0x20, rate 0x02, ctl 0x00 -> BC(k) 01 00 20 02 00 then 4A×10; `ts_done` on the last 4A; then 0x00 idles.
- **TS2 with PAD:** `link_pad`=`lane_pad`=1, `ts_type`=1, continuous `ts_req` -> symbols 1,2 = F7 with k=1; ID 0x45; sets back-to-back with no gap.
- **SKP deferral:** SKP_INTERVAL=20, continuous TS1 -> SKP (BC 1C 1C 1C, `skp_sent` on BC) is inserted only at TS boundaries, never inside a TS. Next SKP starts 20 enabled slots after the previous COM or later.
- **Stall:** drop `sym_en` for 3 cycles at TS `sidx`=7 -> `enc_en`=0 for 3 cycles, output held. The sequence resumes at `sidx`=8 with no symbol lost or duplicated.
- **Error sticky:** pulse `enc_kin_err` -> `kerr_sticky`=1 next cycle. `enc_kin_err` and `kerr_clr` in the same cycle -> stays 1. `kerr_clr` alone -> 0.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// Shared symbol constants and scheduler state type for the transmit-side
// ordered-set scheduler.
// No ports: imported by the scheduler and its sub-blocks.
package pcie_sym_pkg;

  // 8b/10b data bytes; the k flag is carried separately.
  localparam logic [7:0] SYM_COM    = 8'hBC;  // K28.5
  localparam logic [7:0] SYM_SKP    = 8'h1C;  // K28.0
  localparam logic [7:0] SYM_PAD    = 8'hF7;  // K23.7
  localparam logic [7:0] SYM_TS1_ID = 8'h4A;  // D10.2
  localparam logic [7:0] SYM_TS2_ID = 8'h45;  // D5.2
  localparam logic [7:0] SYM_IDL    = 8'h00;  // D0.0

  localparam int unsigned TS_LEN = 16;

  typedef enum logic [1:0] {
    IDLE,
    TS,
    SKP
  } os_state_e;

endpackage

// File: rtl/skp_timer.sv
// SKP interval timer. Counts enabled symbol slots; once SKP_INTERVAL-1 is
// reached it raises pending and saturates until reloaded.
// Ports:
//   clk, rst   - symbol clock, async active-high reset
//   sym_en     - slot enable; timer frozen when low
//   reload     - SKP COM issued this slot: restart interval, drop pending
//   pending    - a SKP ordered set is due
module skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic rst,
  input  logic sym_en,
  input  logic reload,
  output logic pending
);

  localparam int unsigned CW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SKP_INTERVAL - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (sym_en) begin
      if (reload) begin
        cnt     <= '0;
        pending <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt     <= cnt + CW'(1);
        pending <= ((cnt + CW'(1)) == CNT_MAX);
      end
    end
  end

endmodule

// File: rtl/tx_os_scheduler.sv
// Transmit symbol scheduler in front of the 8b/10b encoder. Issues TS1/TS2
// ordered sets on request, inserts SKP ordered sets at a fixed interval and
// fills every other slot with logical idle.
// Ports:
//   clk, rst                 - symbol clock, async active-high reset
//   sym_en                   - slot enable; low freezes everything
//   ts_req, ts_type          - training-set request (level), 0=TS1 1=TS2
//   link_pad, lane_pad       - send PAD in place of link/lane number
//   link_num .. train_ctl    - TS symbols 1..5
//   kerr_clr, enc_kin_err    - sticky K-code error clear / set
//   enc_en, enc_kin, enc_din - registered encoder inputs
//   ts_done, skp_sent        - pulses aligned with last TS / SKP COM symbol
//   os_active                - TS or SKP symbol on enc_din
//   kerr_sticky              - latched encoder K-code error
module tx_os_scheduler
  import pcie_sym_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_LEN      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_en,
  input  logic       ts_req,
  input  logic       ts_type,
  input  logic       link_pad,
  input  logic       lane_pad,
  input  logic [7:0] link_num,
  input  logic [7:0] lane_num,
  input  logic [7:0] n_fts,
  input  logic [7:0] rate_id,
  input  logic [7:0] train_ctl,
  input  logic       kerr_clr,
  input  logic       enc_kin_err,
  output logic       enc_en,
  output logic       enc_kin,
  output logic [7:0] enc_din,
  output logic       ts_done,
  output logic       skp_sent,
  output logic       os_active,
  output logic       kerr_sticky
);

  os_state_e  state, state_d, dec, cur_state;
  logic [3:0] sidx, sidx_d, cur_idx;
  logic       skp_pending, last, reload, capture;
  logic [7:0] sym_din;
  logic       sym_kin;

  // Fields captured on the TS COM slot and held for the whole set.
  logic       cap_ts2, cap_link_pad, cap_lane_pad;
  logic [7:0] cap_link, cap_lane, cap_nfts, cap_rate, cap_ctl;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk    (clk),
    .rst    (rst),
    .sym_en (sym_en),
    .reload (reload),
    .pending(skp_pending)
  );

  always_comb begin
    dec = skp_pending ? SKP : (ts_req ? TS : IDLE);

    // An IDLE slot is itself a boundary: the chosen set starts in this slot.
    // A set's last slot instead decides what starts in the following slot.
    if (state == IDLE) begin
      cur_state = dec;
      cur_idx   = 4'd0;
    end else begin
      cur_state = state;
      cur_idx   = sidx;
    end

    last = ((cur_state == TS)  && (cur_idx == 4'(TS_LEN - 1))) ||
           ((cur_state == SKP) && (cur_idx == 4'(SKP_LEN)));

    reload  = (cur_state == SKP) && (cur_idx == 4'd0);
    capture = (cur_state == TS)  && (cur_idx == 4'd0);

    sym_din = SYM_IDL;
    sym_kin = 1'b0;
    case (cur_state)
      TS: begin
        case (cur_idx)
          4'd0: begin
            sym_din = SYM_COM;
            sym_kin = 1'b1;
          end
          4'd1: begin
            sym_din = cap_link_pad ? SYM_PAD : cap_link;
            sym_kin = cap_link_pad;
          end
          4'd2: begin
            sym_din = cap_lane_pad ? SYM_PAD : cap_lane;
            sym_kin = cap_lane_pad;
          end
          4'd3:    sym_din = cap_nfts;
          4'd4:    sym_din = cap_rate;
          4'd5:    sym_din = cap_ctl;
          default: sym_din = cap_ts2 ? SYM_TS2_ID : SYM_TS1_ID;
        endcase
      end
      SKP: begin
        sym_din = (cur_idx == 4'd0) ? SYM_COM : SYM_SKP;
        sym_kin = 1'b1;
      end
      default: begin
        sym_din = SYM_IDL;
        sym_kin = 1'b0;
      end
    endcase

    if (cur_state == IDLE) begin
      state_d = IDLE;
      sidx_d  = 4'd0;
    end else if (last) begin
      state_d = dec;
      sidx_d  = 4'd0;
    end else begin
      state_d = cur_state;
      sidx_d  = cur_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sidx         <= 4'd0;
      cap_ts2      <= 1'b0;
      cap_link_pad <= 1'b0;
      cap_lane_pad <= 1'b0;
      cap_link     <= 8'h00;
      cap_lane     <= 8'h00;
      cap_nfts     <= 8'h00;
      cap_rate     <= 8'h00;
      cap_ctl      <= 8'h00;
      enc_en       <= 1'b0;
      enc_kin      <= 1'b0;
      enc_din      <= 8'h00;
      ts_done      <= 1'b0;
      skp_sent     <= 1'b0;
      os_active    <= 1'b0;
      kerr_sticky  <= 1'b0;
    end else begin
      enc_en   <= sym_en;
      ts_done  <= 1'b0;
      skp_sent <= 1'b0;
      if (sym_en) begin
        state     <= state_d;
        sidx      <= sidx_d;
        enc_din   <= sym_din;
        enc_kin   <= sym_kin;
        ts_done   <= (cur_state == TS) && last;
        skp_sent  <= reload;
        os_active <= (cur_state != IDLE);
        if (capture) begin
          cap_ts2      <= ts_type;
          cap_link_pad <= link_pad;
          cap_lane_pad <= lane_pad;
          cap_link     <= link_num;
          cap_lane     <= lane_num;
          cap_nfts     <= n_fts;
          cap_rate     <= rate_id;
          cap_ctl      <= train_ctl;
        end
      end
      // Set has priority over clear.
      if (enc_kin_err) begin
        kerr_sticky <= 1'b1;
      end else if (kerr_clr) begin
        kerr_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_os_scheduler.sv
module tb_tx_os_scheduler;

  localparam int unsigned SKP_INTERVAL = 20;
  localparam int unsigned SKP_LEN      = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_en, ts_req, ts_type, link_pad, lane_pad;
  logic [7:0] link_num, lane_num, n_fts, rate_id, train_ctl;
  logic       kerr_clr, enc_kin_err;
  logic       enc_en, enc_kin, ts_done, skp_sent, os_active, kerr_sticky;
  logic [7:0] enc_din;

  tx_os_scheduler #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .SKP_LEN     (SKP_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sym_en     (sym_en),
    .ts_req     (ts_req),
    .ts_type    (ts_type),
    .link_pad   (link_pad),
    .lane_pad   (lane_pad),
    .link_num   (link_num),
    .lane_num   (lane_num),
    .n_fts      (n_fts),
    .rate_id    (rate_id),
    .train_ctl  (train_ctl),
    .kerr_clr   (kerr_clr),
    .enc_kin_err(enc_kin_err),
    .enc_en     (enc_en),
    .enc_kin    (enc_kin),
    .enc_din    (enc_din),
    .ts_done    (ts_done),
    .skp_sent   (skp_sent),
    .os_active  (os_active),
    .kerr_sticky(kerr_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: each ordered set is a list of symbols queued when it
  // starts and drained one per enabled slot.
  typedef struct packed {
    logic [7:0] din;
    logic       kin;
    logic       done;
    logic       skp;
  } sym_t;

  sym_t m_q[$];
  int   m_next;   // 0 none, 1 TS, 2 SKP chosen at the end of the previous set
  int   m_timer;  // enabled slots since the last SKP COM (or reset)
  logic       exp_en, exp_kin, exp_done, exp_skp, exp_act, exp_kerr;
  logic [7:0] exp_din;

  int en_slot;
  int last_skp_slot;
  bit have_last_skp;

  function automatic int decide(bit pend);
    if (pend) return 2;
    if (ts_req) return 1;
    return 0;
  endfunction

  task automatic push_ts();
    sym_t s;
    s = '{din: 8'hBC, kin: 1'b1, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    s = '{din: link_pad ? 8'hF7 : link_num, kin: link_pad, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    s = '{din: lane_pad ? 8'hF7 : lane_num, kin: lane_pad, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    s = '{din: n_fts, kin: 1'b0, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    s = '{din: rate_id, kin: 1'b0, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    s = '{din: train_ctl, kin: 1'b0, done: 1'b0, skp: 1'b0};
    m_q.push_back(s);
    for (int i = 0; i < 10; i++) begin
      s = '{din: ts_type ? 8'h45 : 8'h4A, kin: 1'b0, done: (i == 9), skp: 1'b0};
      m_q.push_back(s);
    end
  endtask

  task automatic push_skp();
    sym_t s;
    s = '{din: 8'hBC, kin: 1'b1, done: 1'b0, skp: 1'b1};
    m_q.push_back(s);
    for (int i = 0; i < int'(SKP_LEN); i++) begin
      s = '{din: 8'h1C, kin: 1'b1, done: 1'b0, skp: 1'b0};
      m_q.push_back(s);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_next   = 0;
    m_timer  = 0;
    exp_en   = 1'b0;
    exp_kin  = 1'b0;
    exp_din  = 8'h00;
    exp_done = 1'b0;
    exp_skp  = 1'b0;
    exp_act  = 1'b0;
    exp_kerr = 1'b0;
    have_last_skp = 1'b0;
  endtask

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic model_slot();
    bit   pend, reload;
    int   nxt;
    sym_t s;
    exp_kerr = enc_kin_err ? 1'b1 : (kerr_clr ? 1'b0 : exp_kerr);
    exp_en   = sym_en;
    exp_done = 1'b0;
    exp_skp  = 1'b0;
    if (!sym_en) return;
    en_slot++;
    pend   = (m_timer >= int'(SKP_INTERVAL) - 1);
    reload = 1'b0;
    if (m_q.size() == 0) begin
      nxt    = (m_next != 0) ? m_next : decide(pend);
      m_next = 0;
      if (nxt == 1) push_ts();
      else if (nxt == 2) push_skp();
    end
    if (m_q.size() == 0) begin
      exp_din = 8'h00;
      exp_kin = 1'b0;
      exp_act = 1'b0;
    end else begin
      s        = m_q.pop_front();
      exp_din  = s.din;
      exp_kin  = s.kin;
      exp_done = s.done;
      exp_skp  = s.skp;
      exp_act  = 1'b1;
      reload   = s.skp;
      if (m_q.size() == 0) m_next = decide(pend);
    end
    m_timer = reload ? 0 : m_timer + 1;
  endtask

  function automatic logic [31:0] obs_vec();
    return {18'd0, enc_en, enc_kin, enc_din, ts_done, skp_sent, os_active, kerr_sticky};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {18'd0, exp_en, exp_kin, exp_din, exp_done, exp_skp, exp_act, exp_kerr};
  endfunction

  // One clock: model consumes the current inputs, outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) model_slot();
    #1;
    check($sformatf("out@%0d", cyc), obs_vec(), exp_vec());
    if (skp_sent === 1'b1 && !rst) begin
      if (have_last_skp) begin
        check("skp_spacing", 32'(en_slot - last_skp_slot >= int'(SKP_INTERVAL)), 32'd1);
      end
      have_last_skp = 1'b1;
      last_skp_slot = en_slot;
    end
  endtask

  // Asynchronous reset asserted mid-cycle, held over one edge, then released.
  task automatic mid_reset(input logic req_at_release);
    #2 rst = 1'b1;
    #1 check("rst_async", obs_vec(), 32'd0);
    model_reset();
    step();
    ts_req = req_at_release;
    rst    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sym_en = 1'b1; ts_req = 1'b0; ts_type = 1'b0;
    link_pad = 1'b0; lane_pad = 1'b0;
    link_num = 8'h00; lane_num = 8'h00; n_fts = 8'h00; rate_id = 8'h00; train_ctl = 8'h00;
    kerr_clr = 1'b0; enc_kin_err = 1'b0;
    en_slot = 0; last_skp_slot = 0;
    model_reset();
    #3 check("rst_init", obs_vec(), 32'd0);
    step();
    rst = 1'b0;

    // Idle after release.
    repeat (2) step();

    // Single TS1, then a 3-cycle stall in the middle of the ID run.
    link_num = 8'h01; lane_num = 8'h00; n_fts = 8'h20; rate_id = 8'h02; train_ctl = 8'h00;
    ts_req = 1'b1;
    step();
    ts_req = 1'b0;
    link_num = 8'hAA; n_fts = 8'h55;  // must not leak into the captured set
    repeat (7) step();
    sym_en = 1'b0;
    repeat (3) step();
    sym_en = 1'b1;
    repeat (30) step();

    // Continuous TS2 with PAD; SKP must only land on set boundaries.
    link_pad = 1'b1; lane_pad = 1'b1; ts_type = 1'b1; ts_req = 1'b1;
    repeat (100) step();
    ts_req = 1'b0; link_pad = 1'b0; lane_pad = 1'b0; ts_type = 1'b0;
    repeat (20) step();

    // Sticky K-code error.
    enc_kin_err = 1'b1;
    step();
    enc_kin_err = 1'b0;
    step();
    enc_kin_err = 1'b1; kerr_clr = 1'b1;
    step();
    enc_kin_err = 1'b0;
    step();
    kerr_clr = 1'b0;
    step();

    // Reset in the middle of a TS, released with ts_req high.
    ts_req = 1'b1;
    repeat (5) step();
    mid_reset(1'b1);
    repeat (20) step();
    ts_req = 1'b0;

    // Randomized traffic with occasional stalls, field changes and resets.
    for (int i = 0; i < 3000; i++) begin
      sym_en = ($urandom_range(9) != 0);
      if ($urandom_range(15) == 0) ts_req = ~ts_req;
      if ($urandom_range(7) == 0) begin
        ts_type   = $urandom_range(1);
        link_pad  = $urandom_range(1);
        lane_pad  = $urandom_range(1);
        link_num  = 8'($urandom);
        lane_num  = 8'($urandom);
        n_fts     = 8'($urandom);
        rate_id   = 8'($urandom);
        train_ctl = 8'($urandom);
      end
      enc_kin_err = ($urandom_range(49) == 0);
      kerr_clr    = ($urandom_range(19) == 0);
      if (i % 700 == 699) begin
        mid_reset(1'($urandom_range(1)));
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
